// File: rtl/flexbex_efpga_responder.sv
// rtl/flexbex_efpga_responder.sv - fixed-function responder for the eFPGA custom-instruction port
module flexbex_efpga_responder #(
  parameter int unsigned MUL_CYCLES = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic [1:0]  operator_i,
  input  logic [31:0] operand_a_i,
  input  logic [31:0] operand_b_i,
  input  logic        write_strobe_i,
  input  logic [3:0]  delay_i,
  output logic [31:0] result_a_o,
  output logic [31:0] result_b_o,
  output logic [31:0] result_c_o,
  output logic        fpga_done_o,
  output logic        busy_o
);

  // Counter must hold both MUL_CYCLES and the largest requested delay (15).
  localparam int unsigned MW = $clog2(MUL_CYCLES + 1);
  localparam int unsigned CW = (MW > 5) ? MW : 5;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_BIT = 2'b10;
  localparam logic [1:0] OP_MAC = 2'b11;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   comp_cyc, lat;
  logic            accept, finish;
  logic            busy_d, done_d;

  logic [1:0]      op_q;
  logic [31:0]     a_q, b_q;
  logic [31:0]     acc_q;
  logic [63:0]     prod_q, mcand_q;
  logic [31:0]     mplier_q;

  logic [1:0]      op_s;
  logic [31:0]     a_s, b_s;
  logic [63:0]     prod_base, mcand_base, prod_step;
  logic [31:0]     mplier_base;
  logic [32:0]     sum33;
  logic [5:0]      pop, clz;
  logic [31:0]     mac_p, acc_new;
  logic [31:0]     res_a_d, res_b_d, res_c_d;

  logic [31:0]     res_a_q, res_b_q, res_c_q;
  logic            done_q, busy_q;

  // Latency of the operation being offered: max(compute cycles, delay_i, 1).
  always_comb begin
    comp_cyc = (operator_i == OP_MUL) ? CW'(MUL_CYCLES) : CW'(1);
    lat      = comp_cyc;
    if (CW'(delay_i) > lat) lat = CW'(delay_i);
    if (lat == '0) lat = CW'(1);
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state: single-cycle ops never leave IDLE; en_i low aborts BUSY.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (write_strobe_i && en_i && lat > CW'(1)) state_d = BUSY;
      BUSY: if (!en_i || cnt_q == CW'(1))               state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs. The counter holds remaining cycles minus one, so the edge
  // that sees cnt_q==1 is the one that raises done for cycle L.
  always_comb begin
    accept = (state_q == IDLE) && write_strobe_i && en_i;
    finish = 1'b0;
    busy_d = 1'b0;
    cnt_d  = '0;
    if (accept) begin
      finish = (lat == CW'(1));
      busy_d = (lat > CW'(1));
      cnt_d  = lat - CW'(1);
    end else if (state_q == BUSY && en_i) begin
      finish = (cnt_q == CW'(1));
      busy_d = (cnt_q > CW'(1));
      cnt_d  = cnt_q - CW'(1);
    end
    done_d = finish;
  end

  // In IDLE the datapath works straight from the inputs so L=1 ops can
  // complete on the accepting edge; in BUSY it uses the captured copies.
  always_comb begin
    if (state_q == BUSY) begin
      op_s        = op_q;
      a_s         = a_q;
      b_s         = b_q;
      prod_base   = prod_q;
      mcand_base  = mcand_q;
      mplier_base = mplier_q;
    end else begin
      op_s        = operator_i;
      a_s         = operand_a_i;
      b_s         = operand_b_i;
      prod_base   = '0;
      mcand_base  = {32'b0, operand_a_i};
      mplier_base = operand_b_i;
    end
    prod_step = prod_base + (mplier_base[0] ? mcand_base : 64'b0);
  end

  // Combinational operators and result selection.
  always_comb begin
    sum33 = {1'b0, a_s} + {1'b0, b_s};
    pop   = '0;
    for (int i = 0; i < 32; i++) pop = pop + 6'(a_s[i]);
    clz   = 6'd32;
    for (int i = 0; i < 32; i++) if (a_s[i]) clz = 6'(31 - i);
    mac_p   = 32'(a_s[15:0]) * 32'(b_s[15:0]);
    acc_new = acc_q + mac_p;
    res_a_d = '0;
    res_b_d = '0;
    res_c_d = '0;
    case (op_s)
      OP_ADD: begin
        res_a_d = sum33[31:0];
        res_b_d = a_s - b_s;
        res_c_d = {31'b0, sum33[32]};
      end
      OP_MUL: begin
        res_a_d = prod_step[31:0];
        res_b_d = prod_step[63:32];
      end
      OP_BIT: begin
        res_a_d = {26'b0, pop};
        res_b_d = {26'b0, clz};
        res_c_d = a_s ^ b_s;
      end
      default: begin
        res_a_d = mac_p;
        res_c_d = acc_new;
      end
    endcase
  end

  // Counter, operand capture and bit-serial multiplier (one b bit per edge,
  // starting on the accepting edge).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (accept) begin
        op_q <= operator_i;
        a_q  <= operand_a_i;
        b_q  <= operand_b_i;
      end
      if (accept || state_q == BUSY) begin
        prod_q   <= prod_step;
        mcand_q  <= mcand_base << 1;
        mplier_q <= mplier_base >> 1;
      end
    end
  end

  // Registered results, accumulator and status; results move only on done.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_a_q <= '0;
      res_b_q <= '0;
      res_c_q <= '0;
      acc_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= done_d;
      busy_q <= busy_d;
      if (finish) begin
        res_a_q <= res_a_d;
        res_b_q <= res_b_d;
        res_c_q <= res_c_d;
        if (op_s == OP_MAC) acc_q <= acc_new;
      end
    end
  end

  assign result_a_o  = res_a_q;
  assign result_b_o  = res_b_q;
  assign result_c_o  = res_c_q;
  assign fpga_done_o = done_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_flexbex_efpga_responder.sv
// tb/tb_flexbex_efpga_responder.sv - scoreboard bench for flexbex_efpga_responder
module tb_flexbex_efpga_responder;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        en_i = 1'b0;
  logic [1:0]  operator_i = '0;
  logic [31:0] operand_a_i = '0;
  logic [31:0] operand_b_i = '0;
  logic        write_strobe_i = 1'b0;
  logic [3:0]  delay_i = '0;
  logic [31:0] result_a_o, result_b_o, result_c_o;
  logic        fpga_done_o, busy_o;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [31:0] acc_m = '0;

  flexbex_efpga_responder #(.MUL_CYCLES(32)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .en_i           (en_i),
    .operator_i     (operator_i),
    .operand_a_i    (operand_a_i),
    .operand_b_i    (operand_b_i),
    .write_strobe_i (write_strobe_i),
    .delay_i        (delay_i),
    .result_a_o     (result_a_o),
    .result_b_o     (result_b_o),
    .result_c_o     (result_c_o),
    .fpga_done_o    (fpga_done_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Reference behaviour of the four operators.
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] ra, output logic [31:0] rb, output logic [31:0] rc);
    logic [63:0] full;
    logic [31:0] p;
    int          z;
    bit          seen;
    ra = 0; rb = 0; rc = 0;
    case (op)
      2'd0: begin
        full = {32'b0, a} + {32'b0, b};
        ra = full[31:0];
        rb = a - b;
        rc = {31'b0, full[32]};
      end
      2'd1: begin
        full = {32'b0, a} * {32'b0, b};
        ra = full[31:0];
        rb = full[63:32];
      end
      2'd2: begin
        z = 0; seen = 0;
        for (int i = 31; i >= 0; i--) begin
          if (!seen) begin
            if (a[i]) seen = 1;
            else z++;
          end
        end
        ra = $countones(a);
        rb = z;
        rc = a ^ b;
      end
      default: begin
        p = {16'b0, a[15:0]} * {16'b0, b[15:0]};
        acc_m = acc_m + p;
        ra = p;
        rc = acc_m;
      end
    endcase
  endtask

  // Drive one strobe in the current cycle (cycle 0); returns in cycle 1.
  task automatic start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] d, input bit push);
    exp_t e;
    int   c;
    int   l;
    c = (op == 2'd1) ? 32 : 1;
    l = (int'(d) > c) ? int'(d) : c;
    operator_i = op;
    operand_a_i = a;
    operand_b_i = b;
    delay_i = d;
    en_i = 1'b1;
    write_strobe_i = 1'b1;
    if (push) begin
      model(op, a, b, e.a, e.b, e.c);
      e.cyc = cyc + l;
      sb.push_back(e);
    end
    tick();
    write_strobe_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 80) begin
      tick();
      n++;
    end
    check("drain", sb.size(), 0);
    if (sb.size() != 0) sb.delete();
    tick();
  endtask

  // Completion monitor: every done pulse must match the head of the scoreboard.
  always @(negedge clk_i) begin
    if (rst_ni && fpga_done_o) begin
      if (sb.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_cycle", cyc, e.cyc);
        check("res_a", result_a_o, e.a);
        check("res_b", result_b_o, e.b);
        check("res_c", result_c_o, e.c);
      end
    end
  end

  initial begin
    logic [31:0] sa, sb_, sc;

    repeat (3) tick();
    check("rst_a", result_a_o, 0);
    check("rst_b", result_b_o, 0);
    check("rst_c", result_c_o, 0);
    check("rst_done", fpga_done_o, 0);
    check("rst_busy", busy_o, 0);
    rst_ni = 1'b1;
    en_i = 1'b1;
    tick();

    // ADD with L=1: busy never rises.
    start(2'd0, 32'hFFFF_FFFF, 32'h0000_0001, 4'd0, 1);
    check("add_busy_c1", busy_o, 0);
    drain();

    // MUL full range: busy in cycles 1..31, low in cycle 32.
    start(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5, 1);
    for (int k = 1; k <= 31; k++) begin
      check("mul_busy", busy_o, 1);
      tick();
    end
    check("mul_busy_c32", busy_o, 0);
    drain();

    // Delay stretch with BIT.
    start(2'd2, 32'h0, 32'h0000_F00F, 4'd9, 1);
    drain();

    // Two MACs, the second strobed in the first one's done cycle.
    start(2'd3, 32'h0001_0003, 32'h0000_0005, 4'd0, 1);
    start(2'd3, 32'h0001_0003, 32'h0000_0005, 4'd0, 1);
    drain();
    check("mac_acc", result_c_o, 30);

    // Mixed random operations.
    for (int n = 0; n < 10; n++) begin
      start(2'($urandom_range(0, 3)), $urandom, $urandom, 4'($urandom_range(0, 15)), 1);
      drain();
    end

    // Abort: ignored strobe at cycle 4, en_i low at cycle 10.
    sa = result_a_o; sb_ = result_b_o; sc = result_c_o;
    start(2'd1, 32'd3, 32'd7, 4'd0, 0);
    repeat (3) tick();
    operator_i = 2'd0;
    operand_a_i = 32'h1234;
    operand_b_i = 32'h5678;
    write_strobe_i = 1'b1;
    tick();
    write_strobe_i = 1'b0;
    repeat (5) tick();
    check("abort_busy_c10", busy_o, 1);
    en_i = 1'b0;
    tick();
    check("abort_busy_c11", busy_o, 0);
    repeat (30) tick();
    check("abort_hold_a", result_a_o, sa);
    check("abort_hold_b", result_b_o, sb_);
    check("abort_hold_c", result_c_o, sc);
    start(2'd0, 32'd100, 32'd58, 4'd3, 1);
    drain();

    // Reset in the middle of a MUL.
    start(2'd1, 32'hDEAD_BEEF, 32'h1234_5678, 4'd0, 0);
    repeat (14) tick();
    rst_ni = 1'b0;
    #1;
    check("mrst_a", result_a_o, 0);
    check("mrst_b", result_b_o, 0);
    check("mrst_c", result_c_o, 0);
    check("mrst_done", fpga_done_o, 0);
    check("mrst_busy", busy_o, 0);
    acc_m = '0;
    sb.delete();
    repeat (2) tick();
    rst_ni = 1'b1;
    tick();
    start(2'd3, 32'd2, 32'd3, 4'd0, 1);
    drain();
    check("mac_after_rst", result_c_o, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
